// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Single write port arbiter for a register file. Two requesters share the
//   port: A (ALU writeback) and B (load unit). After reset the block sweeps
//   registers 0..NREGS-1 with zeros (CLEAR). It then arbitrates round-robin
//   between A and B (RUN). An accepted write appears on the register file
//   port exactly one cycle later.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   a_valid     in   requester A has a write pending
//   a_addr      in   requester A target register   [ADDR_W]
//   a_data      in   requester A write data        [DATA_W]
//   a_ready     out  requester A accepted this cycle (when a_valid)
//   b_valid     in   requester B has a write pending
//   b_addr      in   requester B target register   [ADDR_W]
//   b_data      in   requester B write data        [DATA_W]
//   b_ready     out  requester B accepted this cycle (when b_valid)
//   rf_hold     in   register file busy, accept nothing new
//   rf_we       out  register file write enable
//   rf_waddr    out  register file write address   [ADDR_W]
//   rf_wdata    out  register file write data      [DATA_W]
//   clear_done  out  post-reset sweep has finished
//
// Configuration macro:
//   RFARB_ZERO_REG_EN - when defined, accepted writes to register 0 complete
//   the handshake but are dropped (rf_we stays 0), so register 0 reads as
//   zero forever. The CLEAR sweep is unaffected.
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              rf_hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              clear_done
);

    // One extra bit so the counter can reach NREGS even when NREGS == 2^ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(NREGS);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_b_q;      // 1: B was granted most recently
    logic              clear_done_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    logic              acc_a;
    logic              acc_b;
    logic              acc;
    logic              issue;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              last_b_d;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;

    // Grant: A wins a tie unless A was the most recent winner.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == RUN && !rf_hold) begin
            if (a_valid && (!b_valid || last_b_q)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    always_comb begin
        acc_a    = a_valid & a_ready;
        acc_b    = b_valid & b_ready;
        acc      = acc_a | acc_b;
        sel_addr = acc_b ? b_addr : a_addr;
        sel_data = acc_b ? b_data : a_data;
        last_b_d = acc_b ? 1'b1 : (acc_a ? 1'b0 : last_b_q);
`ifdef RFARB_ZERO_REG_EN
        // Writes to register 0 are accepted but swallowed.
        issue    = acc && (sel_addr != '0);
`else
        issue    = acc;
`endif
        rf_we_d    = issue;
        rf_waddr_d = issue ? sel_addr : rf_waddr_q;
        rf_wdata_d = issue ? sel_data : rf_wdata_q;
    end

    // Capture stage: accepted request -> register file port, one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            last_b_q     <= 1'b1;
            clear_done_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    // The counter runs one past the last register so the
                    // final sweep write is still visible while in CLEAR;
                    // readies therefore stay low for the whole sweep.
                    if (cnt_q == SWEEP_END) begin
                        state_q      <= RUN;
                        clear_done_q <= 1'b1;
                        rf_we_q      <= 1'b0;
                    end else begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= cnt_q[ADDR_W-1:0];
                        rf_wdata_q <= '0;
                        cnt_q      <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    rf_we_q    <= rf_we_d;
                    rf_waddr_q <= rf_waddr_d;
                    rf_wdata_q <= rf_wdata_d;
                    last_b_q   <= last_b_d;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Bench for regfile_write_arbiter with default parameters (DATA_W=16,
// ADDR_W=5, NREGS=16). Honours RFARB_ZERO_REG_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 16;

    logic              clock;
    logic              reset;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_hold;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              clear_done;

    int total;
    int bad;

    regfile_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_hold   (rf_hold),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .clear_done(clear_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              bv;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        logic              hold;
        logic              ear;
        logic              ebr;
        logic              ewe;
        logic [ADDR_W-1:0] ewa;
        logic [DATA_W-1:0] ewd;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks a full sweep starting from the cycle after reset release.
    // Requesters are kept valid and rf_hold toggled to show both are ignored.
    task automatic sweep_check();
        a_valid = 1'b1; a_addr = 5'd7;  a_data = 16'h1234;
        b_valid = 1'b1; b_addr = 5'd20; b_data = 16'h4321;
        for (int i = 0; i < NREGS; i++) begin
            rf_hold = i[0];
            tick();
            chk("sweep_we",   32'(rf_we), 32'd1);
            chk("sweep_addr", 32'(rf_waddr), 32'(i));
            chk("sweep_data", 32'(rf_wdata), 32'd0);
            chk("sweep_done", 32'(clear_done), 32'd0);
            chk("sweep_ardy", 32'(a_ready), 32'd0);
            chk("sweep_brdy", 32'(b_ready), 32'd0);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rf_hold = 1'b0;
        tick();
        chk("done_rise", 32'(clear_done), 32'd1);
        chk("done_we",   32'(rf_we), 32'd0);
    endtask

    initial begin
        logic              m_av, m_bv, m_last_a, m_hold;
        logic [ADDR_W-1:0] m_aa, m_ba, m_waddr;
        logic [DATA_W-1:0] m_ad, m_bd, m_wdata;
        logic              g_a, g_b, e_we;

        total = 0;
        bad   = 0;

        // Row order matters: the last-grant pointer carries between rows.
        //              av    aa     ad         bv    ba      bd         hold  ear   ebr   ewe   ewa     ewd
        tbl[0]  = '{1'b1, 5'd3,  16'hBEEF, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  16'hBEEF};
        tbl[1]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd7,  16'h0707, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  16'h0707};
        tbl[2]  = '{1'b1, 5'd1,  16'h0001, 1'b1, 5'd9,  16'h0009, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  16'h0001};
        tbl[3]  = '{1'b1, 5'd2,  16'h0002, 1'b1, 5'd9,  16'h0009, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  16'h0009};
        tbl[4]  = '{1'b1, 5'd2,  16'h0002, 1'b1, 5'd10, 16'h000A, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  16'h0002};
        tbl[5]  = '{1'b1, 5'd3,  16'h0003, 1'b1, 5'd10, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 16'h000A};
        tbl[6]  = '{1'b0, 5'd3,  16'h0003, 1'b0, 5'd11, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 16'h000A};
        tbl[7]  = '{1'b1, 5'd3,  16'h0003, 1'b1, 5'd11, 16'h000B, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 16'h000A};
        tbl[8]  = '{1'b1, 5'd3,  16'h0003, 1'b1, 5'd11, 16'h000B, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 16'h000A};
        tbl[9]  = '{1'b1, 5'd3,  16'h0003, 1'b1, 5'd11, 16'h000B, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 16'h000A};
        tbl[10] = '{1'b1, 5'd3,  16'h0003, 1'b1, 5'd11, 16'h000B, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  16'h0003};
        tbl[11] = '{1'b0, 5'd3,  16'h0003, 1'b1, 5'd11, 16'h000B, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  16'h0003};
`ifdef RFARB_ZERO_REG_EN
        tbl[12] = '{1'b1, 5'd0,  16'h5555, 1'b0, 5'd11, 16'h000B, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  16'h0003};
`else
        tbl[12] = '{1'b1, 5'd0,  16'h5555, 1'b0, 5'd11, 16'h000B, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  16'h5555};
`endif
        tbl[13] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd11, 16'h000B, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 16'h000B};

        // Reset state
        reset   = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        rf_hold = 1'b0;
        tick();
        chk("rst_we",   32'(rf_we), 32'd0);
        chk("rst_addr", 32'(rf_waddr), 32'd0);
        chk("rst_data", 32'(rf_wdata), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_ardy", 32'(a_ready), 32'd0);
        reset = 1'b0;
        sweep_check();

        // Table-driven RUN vectors
        for (int i = 0; i < 14; i++) begin
            a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
            rf_hold = tbl[i].hold;
            #1;
            chk($sformatf("vec%0d_ardy", i), 32'(a_ready), 32'(tbl[i].ear));
            chk($sformatf("vec%0d_brdy", i), 32'(b_ready), 32'(tbl[i].ebr));
            tick();
            chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(tbl[i].ewe));
            chk($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(tbl[i].ewa));
            chk($sformatf("vec%0d_data", i), 32'(rf_wdata), 32'(tbl[i].ewd));
            chk($sformatf("vec%0d_done", i), 32'(clear_done), 32'd1);
        end

        // Reset while B's write is accepted: it must never be issued.
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd12; b_data = 16'hDEAD;
        rf_hold = 1'b0;
        #1;
        chk("midrst_brdy", 32'(b_ready), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_we",   32'(rf_we), 32'd0);
        chk("midrst_addr", 32'(rf_waddr), 32'd0);
        chk("midrst_data", 32'(rf_wdata), 32'd0);
        chk("midrst_done", 32'(clear_done), 32'd0);
        reset   = 1'b0;
        b_valid = 1'b0;
        sweep_check();

        // Randomised traffic against a request-level model.
        m_av = 1'b0; m_bv = 1'b0;
        m_aa = '0; m_ba = '0; m_ad = '0; m_bd = '0;
        m_last_a = 1'b0;                // reset leaves B as last winner
        m_waddr  = ADDR_W'(NREGS - 1);  // last sweep write
        m_wdata  = '0;
        for (int c = 0; c < 600; c++) begin
            // A requester with nothing pending may raise a new request.
            if (!m_av && ($urandom_range(0, 9) < 6)) begin
                m_av = 1'b1;
                m_aa = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                m_ad = DATA_W'($urandom);
            end
            if (!m_bv && ($urandom_range(0, 9) < 6)) begin
                m_bv = 1'b1;
                m_ba = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                m_bd = DATA_W'($urandom);
            end
            m_hold = ($urandom_range(0, 3) == 0);

            a_valid = m_av; a_addr = m_aa; a_data = m_ad;
            b_valid = m_bv; b_addr = m_ba; b_data = m_bd;
            rf_hold = m_hold;

            g_a = 1'b0;
            g_b = 1'b0;
            if (!m_hold) begin
                if (m_av && m_bv) begin
                    if (m_last_a) g_b = 1'b1;
                    else          g_a = 1'b1;
                end else begin
                    g_a = m_av;
                    g_b = m_bv;
                end
            end

            #1;
            chk("rnd_ardy", 32'(a_ready), 32'(g_a));
            chk("rnd_brdy", 32'(b_ready), 32'(g_b));

            e_we = g_a | g_b;
`ifdef RFARB_ZERO_REG_EN
            if (g_a && m_aa == 0) e_we = 1'b0;
            if (g_b && m_ba == 0) e_we = 1'b0;
`endif
            if (e_we) begin
                m_waddr = g_a ? m_aa : m_ba;
                m_wdata = g_a ? m_ad : m_bd;
            end
            if (g_a) begin m_av = 1'b0; m_last_a = 1'b1; end
            if (g_b) begin m_bv = 1'b0; m_last_a = 1'b0; end

            tick();
            chk("rnd_we",   32'(rf_we), 32'(e_we));
            chk("rnd_addr", 32'(rf_waddr), 32'(m_waddr));
            chk("rnd_data", 32'(rf_wdata), 32'(m_wdata));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: data width of the register file write port, in bits.
REQ-002 Parameter ADDR_W, default 5: width of the register address.
REQ-003 Parameter NREGS, default 16: number of registers swept after reset; SHALL be no greater than 2^ADDR_W.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 a_addr  input  ADDR_W  requester A target register.
REQ-008 a_data  input  DATA_W  requester A write data.
REQ-009 a_ready  output  1  requester A write is accepted this cycle when a_valid is also high.
REQ-010 b_valid, b_addr, b_data, b_ready  as REQ-006..009, for requester B (load unit).
REQ-011 rf_hold  input  1  register file is busy; no new write may be accepted.
REQ-012 rf_we  output  1  write enable to the register file (controlRegWrite).
REQ-013 rf_waddr  output  ADDR_W  register file write address (writeReg).
REQ-014 rf_wdata  output  DATA_W  register file write data (writeData).
REQ-015 clear_done  output  1  post-reset register sweep is complete.

Function
REQ-016 The FSM SHALL have two states, CLEAR and RUN; reset enters CLEAR.
REQ-017 In CLEAR, a sweep counter SHALL step 0..NREGS-1, one per cycle, driving rf_we=1, rf_waddr=counter, rf_wdata=0.
REQ-018 The sweep SHALL ignore rf_hold; after the NREGS-1 write, the FSM SHALL go to RUN and assert clear_done, which SHALL stay high until the next reset.
REQ-019 a_ready and b_ready SHALL be 0 in CLEAR and whenever rf_hold=1.
REQ-020 In RUN with rf_hold=0: if only one requester is valid, that requester's ready SHALL be 1; if neither is valid, both readies SHALL be 0.
REQ-021 In RUN with rf_hold=0 and both requesters valid, grant SHALL be round-robin: the requester not granted most recently wins.
REQ-022 The last-grant pointer SHALL update only on an accepted transfer.
REQ-023 a_ready and b_ready SHALL never be high in the same cycle; ready SHALL depend combinationally on valid, rf_hold, state and the last-grant pointer only.
REQ-024 An accepted transfer SHALL produce rf_we=1 with the captured addr/data on the next cycle, a latency of exactly 1.
REQ-025 With no acceptance in a RUN cycle, rf_we SHALL be 0 on the next cycle; rf_waddr and rf_wdata SHALL hold their last values.
REQ-026 Throughput SHALL be one accepted write per cycle, with back-to-back acceptance permitted.
REQ-027 A requester SHALL keep valid, addr and data stable until accepted; the block does not check this.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL load: state=CLEAR, sweep counter=0, last-grant=B (so A wins the first tie), clear_done=0.
REQ-029 The outputs registered at that edge SHALL be rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-030 Reset asserted mid-sweep or mid-RUN SHALL discard any captured write and restart the sweep from 0.

Configuration
REQ-031 With macro RFARB_ZERO_REG_EN defined, accepted writes to address 0 SHALL complete the handshake but SHALL produce rf_we=0, leaving register 0 hard-wired zero.
REQ-032 With RFARB_ZERO_REG_EN undefined, writes to address 0 SHALL be issued like any other address.
REQ-033 RFARB_ZERO_REG_EN SHALL NOT affect the CLEAR sweep.

Verification
REQ-034 Reset 1 cycle, then release -> rf_we=1 for 16 cycles, addresses 0..15, data 0; clear_done rises on cycle 17; readies stay 0 throughout the sweep.
REQ-035 After clear, a_valid=1, a_addr=3, a_data=16'hBEEF -> a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=16'hBEEF.
REQ-036 Both valid for 4 cycles (A: addr 1..4, B: addr 9..12, advanced on acceptance) -> grants A,B,A,B; rf_waddr sequence 1,9,2,10.
REQ-037 Both valid with rf_hold=1 for 3 cycles -> both readies 0 and rf_we=0; on release, A is granted first.
REQ-038 Reset asserted for 1 cycle mid-RUN while B's write is captured -> that write is never issued; the sweep restarts at address 0.
REQ-039 With RFARB_ZERO_REG_EN defined, a_addr=0 accepted -> a_ready=1, rf_we=0 next cycle; without the macro, rf_we=1, rf_waddr=0.
